not_bitwise: RTL and testbench



---
 rtl/not_bitwise_pkg.sv | 15 +
 rtl/not_bitwise_monitor.sv | 41 ++++
 rtl/not_bitwise.sv | 55 +++++
 tb/tb_not_bitwise.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/not_bitwise_pkg.sv
// Shared types and constants for the four-lane registered inverter.
// Latency: n/a (declarations only).
// Backpressure: none; the block is a free-running datapath leaf.
package not_bitwise_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int LANES         = 4;

  // Lane 1 sits in the MSB so {out1..out4} reads left to right
  typedef logic [LANES-1:0] lane_vec_t;

  // Outputs after reset: the complement of all-zero inputs
  localparam lane_vec_t RESET_VEC = '1;

endpackage

// File: rtl/not_bitwise_monitor.sv
// Output-change monitor: one-cycle change pulse plus a saturating change counter.
// Latency: one clock; pulse and count update on the edge where the outputs change.
// Backpressure: none; it observes every edge and cannot stall.
module not_bitwise_monitor
  import not_bitwise_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  lane_vec_t        i_next,
  input  lane_vec_t        i_cur,
  output logic             o_changed,
  output logic [CNT_W-1:0] o_count
);

  logic             r_changed;
  logic [CNT_W-1:0] r_count;
  logic             w_diff;
  logic             w_sat;

  assign w_diff = (i_next != i_cur);
  assign w_sat  = &r_count;

  // Register the change pulse and bump the counter on the same edge, holding at max
  always_ff @(posedge clk) begin
    if (rst) begin
      r_changed <= 1'b0;
      r_count   <= '0;
    end else begin
      r_changed <= w_diff;
      if (w_diff && !w_sat) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_changed = r_changed;
  assign o_count   = r_count;

endmodule

// File: rtl/not_bitwise.sv
// Four-lane registered bitwise inverter with optional change monitor (NOT_BITWISE_MONITOR_EN).
// Latency: one clock from in_k to out_k; no combinational input-to-output path.
// Backpressure: none; new inputs are captured every rising edge.
module not_bitwise
  import not_bitwise_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1,
  input  logic             in2,
  input  logic             in3,
  input  logic             in4,
  output logic             out1,
  output logic             out2,
  output logic             out3,
  output logic             out4,
  output logic             changed,
  output logic [CNT_W-1:0] change_count
);

  lane_vec_t r_out;
  lane_vec_t w_next;

  assign w_next = ~{in1, in2, in3, in4};

  // Capture the inverted lanes; reset restores the all-ones vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= RESET_VEC;
    end else begin
      r_out <= w_next;
    end
  end

  assign {out1, out2, out3, out4} = r_out;

`ifdef NOT_BITWISE_MONITOR_EN
  not_bitwise_monitor #(
    .CNT_W (CNT_W)
  ) u_monitor (
    .clk       (clk),
    .rst       (rst),
    .i_next    (w_next),
    .i_cur     (r_out),
    .o_changed (changed),
    .o_count   (change_count)
  );
`else
  assign changed      = 1'b0;
  assign change_count = '0;
`endif

endmodule

// File: tb/tb_not_bitwise.sv
// Scoreboard bench for not_bitwise: two instances (CNT_W=8 and CNT_W=2) share stimulus.
// Latency: expected values are checked one edge after the inputs are applied.
// Backpressure: none.
module tb_not_bitwise;

  logic       clk = 1'b0;
  logic       rst;
  logic       in1, in2, in3, in4;
  logic       a1, a2, a3, a4, a_ch;
  logic       b1, b2, b3, b4, b_ch;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

`ifdef NOT_BITWISE_MONITOR_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  not_bitwise #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(a1), .out2(a2), .out3(a3), .out4(a4),
    .changed(a_ch), .change_count(a_cnt)
  );

  not_bitwise #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(b1), .out2(b2), .out3(b3), .out4(b4),
    .changed(b_ch), .change_count(b_cnt)
  );

  typedef struct {
    logic [3:0] out;
    logic       ch;
    int         c8;
    int         c2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state (written only by the driver)
  logic [3:0] m_out;
  int         m_c8;
  int         m_c2;

  task automatic step(input logic r, input logic [3:0] v);
    exp_t e;
    logic [3:0] n;
    logic ch;
    @(negedge clk);
    rst = r;
    {in1, in2, in3, in4} = v;
    if (r) begin
      m_out = 4'b1111;
      ch    = 1'b0;
      m_c8  = 0;
      m_c2  = 0;
    end else begin
      n  = 4'b1111 ^ v;
      ch = (n != m_out);
      m_out = n;
      if (ch) begin
        m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
        m_c2 = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
      end
    end
    e.out = m_out;
    e.ch  = MON_EN ? ch : 1'b0;
    e.c8  = MON_EN ? m_c8 : 0;
    e.c2  = MON_EN ? m_c2 : 0;
    q.push_back(e);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented output against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_int("out_w8",   int'({a1, a2, a3, a4}), int'(e.out));
        check_int("out_w2",   int'({b1, b2, b3, b4}), int'(e.out));
        check_int("changed_w8", int'(a_ch), int'(e.ch));
        check_int("changed_w2", int'(b_ch), int'(e.ch));
        check_int("count_w8", int'(a_cnt), e.c8);
        check_int("count_w2", int'(b_cnt), e.c2);
      end
    end
  end

  // Driver
  initial begin
    rst = 1'b1;
    {in1, in2, in3, in4} = 4'b1010;
    m_out = 4'b1111;
    m_c8  = 0;
    m_c2  = 0;

    // Reset held two cycles with non-zero inputs
    step(1'b1, 4'b1010);
    step(1'b1, 4'b1010);

    // Exhaustive sweep, in4 fastest
    for (int v = 0; v < 16; v++) step(1'b0, v[3:0]);

    // Quiet inputs then a single-lane change
    step(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
    step(1'b0, 4'b0001);

    // Saturation: toggle in1 every cycle from reset
    step(1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b0, (i % 2 == 0) ? 4'b1000 : 4'b0000);

    // Reset mid-run after reaching a non-zero count, then a quiet edge
    step(1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) step(1'b0, (i % 2 == 0) ? 4'b0100 : 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0000);

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)));
    end

    // Drain, bounded
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
